// File: rtl/usb_host_chirp_if.sv
`default_nettype none
// ============================================================================
// Module : usb_host_chirp_if
// Brief  : ULPI-side handshake, register and status bundle of the host chirp
//          sequencer. master = sequencer, slave = ULPI wrapper / top level.
// Rev    : 1.0  initial release
// ============================================================================
interface usb_host_chirp_if;
  logic       START;
  logic       READY;
  logic [7:0] RXCMD;
  logic       REG_EN;
  logic       REG_RW;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I;
  logic       REG_DONE;
  logic       REG_FAIL;
  logic [7:0] USB_DATA_IN;
  logic       USB_DATA_IN_START_END;
  logic       USB_DATA_IN_STRB;
  logic       USB_DATA_IN_FAIL;
  logic       BUSY;
  logic       HS_OK;
  logic       FS_FALLBACK;
  logic       ERR;
  logic [3:0] STATE;

  modport master (
    input  START, READY, RXCMD, REG_DONE, REG_FAIL,
           USB_DATA_IN_STRB, USB_DATA_IN_FAIL,
    output REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
           USB_DATA_IN, USB_DATA_IN_START_END,
           BUSY, HS_OK, FS_FALLBACK, ERR, STATE
  );

  modport slave (
    output START, READY, RXCMD, REG_DONE, REG_FAIL,
           USB_DATA_IN_STRB, USB_DATA_IN_FAIL,
    input  REG_EN, REG_RW, REG_ADDR, REG_DATA_I,
           USB_DATA_IN, USB_DATA_IN_START_END,
           BUSY, HS_OK, FS_FALLBACK, ERR, STATE
  );
endinterface
`default_nettype wire

// File: rtl/usb_host_chirp.sv
`default_nettype none
// ============================================================================
// Module : usb_host_chirp
// Brief  : Host-side USB 2.0 high-speed detection handshake over ULPI: chirp
//          OpMode write, device Chirp K qualification, host K-J train, HS
//          switch or full-speed fallback. Optional macro
//          USB_HOST_CHIRP_RETRY_EN adds one automatic retry on REG/TX failure.
// Rev    : 1.0  initial release
// ============================================================================
module usb_host_chirp #(
  parameter int unsigned CHIRP_K_DET_CYC   = 150,
  parameter int unsigned CHIRP_TIMEOUT_CYC = 420000,
  parameter int unsigned RESET_CYC         = 600000,
  parameter int unsigned KJ_CYC            = 3000,
  parameter int unsigned KJ_PAIRS_MIN      = 3
) (
  input  logic             CLK_60M,
  input  logic             NRST_A_USB,
  usb_host_chirp_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_CHIRP   = 4'd1,
    ST_WAIT_WR1   = 4'd2,
    ST_WAIT_CHIRP = 4'd3,
    ST_WAIT_K_END = 4'd4,
    ST_TX_START   = 4'd5,
    ST_TX_K       = 4'd6,
    ST_TX_J       = 4'd7,
    ST_TX_END     = 4'd8,
    ST_WR_HS      = 4'd9,
    ST_WAIT_WR2   = 4'd10,
    ST_HS_DONE    = 4'd11,
    ST_FS_DONE    = 4'd12,
    ST_FAIL       = 4'd13
  } state_e;

  localparam logic [5:0]  FUNC_CTRL_ADDR = 6'h04;
  localparam logic [7:0]  FC_CHIRP       = 8'h50;
  localparam logic [7:0]  FC_HS          = 8'h40;
  localparam logic [7:0]  K_BYTE         = 8'h00;
  localparam logic [7:0]  J_BYTE         = 8'hFF;
  localparam logic [1:0]  LS_K           = 2'b10;
  localparam logic [31:0] CNT_MAX        = 32'hFFFF_FFFF;
  localparam logic [7:0]  PAIRS_MAX      = 8'hFF;

  state_e      state_q, state_d;
  logic [31:0] t_q, t_d;
  logic [31:0] kcnt_q, kcnt_d;
  logic [31:0] c_q, c_d;
  logic [7:0]  pairs_q, pairs_d;

  logic        reg_en_q, reg_en_d;
  logic        reg_rw_q, reg_rw_d;
  logic [5:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        start_end_q, start_end_d;
  logic        busy_q, busy_d;
  logic        hs_ok_q, hs_ok_d;
  logic        fs_q, fs_d;
  logic        err_q, err_d;

`ifdef USB_HOST_CHIRP_RETRY_EN
  logic        retry_q, retry_d;
`endif

  logic        line_k;
  logic        fail_req;
  logic        pair_min_met;
  logic [31:0] t_inc;
  logic [31:0] kcnt_inc;
  logic [31:0] c_inc;
  logic [7:0]  pairs_inc;

  assign line_k    = (bus.RXCMD[1:0] == LS_K);
  assign t_inc     = (t_q == CNT_MAX) ? t_q : t_q + 32'd1;
  assign kcnt_inc  = (kcnt_q == CNT_MAX) ? kcnt_q : kcnt_q + 32'd1;
  assign c_inc     = (c_q == CNT_MAX) ? c_q : c_q + 32'd1;
  assign pairs_inc = (pairs_q == PAIRS_MAX) ? pairs_q : pairs_q + 8'd1;
  // Pair count including the J chirp that is finishing this cycle.
  assign pair_min_met = ({24'd0, pairs_q} + 32'd1) >= KJ_PAIRS_MIN;

  // Next-state and counter update.
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    kcnt_d   = kcnt_q;
    c_d      = c_q;
    pairs_d  = pairs_q;
    fail_req = 1'b0;
`ifdef USB_HOST_CHIRP_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE, ST_HS_DONE, ST_FS_DONE, ST_FAIL: begin
        if (bus.START && bus.READY) begin
          state_d = ST_WR_CHIRP;
`ifdef USB_HOST_CHIRP_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      ST_WR_CHIRP: state_d = ST_WAIT_WR1;
      ST_WAIT_WR1: begin
        if (bus.REG_DONE) begin
          state_d = ST_WAIT_CHIRP;
          t_d     = 32'd0;
          kcnt_d  = 32'd0;
        end else if (bus.REG_FAIL) begin
          fail_req = 1'b1;
        end
      end
      ST_WAIT_CHIRP: begin
        t_d    = t_inc;
        kcnt_d = line_k ? kcnt_inc : 32'd0;
        // A qualifying K on the timeout cycle still wins.
        if (line_k && (kcnt_q == CHIRP_K_DET_CYC - 1)) begin
          state_d = ST_WAIT_K_END;
        end else if (t_q >= CHIRP_TIMEOUT_CYC) begin
          state_d = ST_FS_DONE;
        end
      end
      ST_WAIT_K_END: begin
        t_d = t_inc;
        if (!line_k) begin
          state_d = ST_TX_START;
        end else if (t_q >= RESET_CYC) begin
          state_d = ST_FAIL;
        end
      end
      ST_TX_START: begin
        t_d     = t_inc;
        c_d     = 32'd0;
        pairs_d = 8'd0;
        if (bus.USB_DATA_IN_FAIL) begin
          fail_req = 1'b1;
        end else begin
          state_d = ST_TX_K;
        end
      end
      ST_TX_K: begin
        t_d = t_inc;
        if (bus.USB_DATA_IN_FAIL) begin
          fail_req = 1'b1;
        end else if (c_q == KJ_CYC - 1) begin
          state_d = ST_TX_J;
          c_d     = 32'd0;
        end else begin
          c_d = c_inc;
        end
      end
      ST_TX_J: begin
        t_d = t_inc;
        if (bus.USB_DATA_IN_FAIL) begin
          fail_req = 1'b1;
        end else if (c_q == KJ_CYC - 1) begin
          c_d     = 32'd0;
          pairs_d = pairs_inc;
          state_d = (pair_min_met && (t_q >= RESET_CYC)) ? ST_TX_END : ST_TX_K;
        end else begin
          c_d = c_inc;
        end
      end
      ST_TX_END:   state_d = ST_WR_HS;
      ST_WR_HS:    state_d = ST_WAIT_WR2;
      ST_WAIT_WR2: begin
        if (bus.REG_DONE) begin
          state_d = ST_HS_DONE;
        end else if (bus.REG_FAIL) begin
          fail_req = 1'b1;
        end
      end
      default:     state_d = ST_IDLE;
    endcase

    if (fail_req) begin
`ifdef USB_HOST_CHIRP_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = ST_WR_CHIRP;
      end else begin
        state_d = ST_FAIL;
      end
`else
      state_d = ST_FAIL;
`endif
    end
  end

  // Moore output decode of the next state, registered alongside it.
  always_comb begin
    reg_en_d    = 1'b0;
    reg_rw_d    = 1'b0;
    reg_addr_d  = 6'd0;
    reg_data_d  = 8'd0;
    tx_data_d   = K_BYTE;
    start_end_d = 1'b0;
    busy_d      = 1'b0;
    hs_ok_d     = 1'b0;
    fs_d        = 1'b0;
    err_d       = 1'b0;
    case (state_d)
      ST_WR_CHIRP: begin
        reg_en_d   = 1'b1;
        reg_rw_d   = 1'b1;
        reg_addr_d = FUNC_CTRL_ADDR;
        reg_data_d = FC_CHIRP;
        busy_d     = 1'b1;
      end
      ST_WR_HS: begin
        reg_en_d   = 1'b1;
        reg_rw_d   = 1'b1;
        reg_addr_d = FUNC_CTRL_ADDR;
        reg_data_d = FC_HS;
        busy_d     = 1'b1;
      end
      ST_TX_START, ST_TX_END: begin
        start_end_d = 1'b1;
        busy_d      = 1'b1;
      end
      ST_TX_J: begin
        tx_data_d = J_BYTE;
        busy_d    = 1'b1;
      end
      ST_WAIT_WR1, ST_WAIT_CHIRP, ST_WAIT_K_END, ST_TX_K, ST_WAIT_WR2: begin
        busy_d = 1'b1;
      end
      ST_HS_DONE: hs_ok_d = 1'b1;
      ST_FS_DONE: fs_d    = 1'b1;
      ST_FAIL:    err_d   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q     <= ST_IDLE;
      t_q         <= 32'd0;
      kcnt_q      <= 32'd0;
      c_q         <= 32'd0;
      pairs_q     <= 8'd0;
      reg_en_q    <= 1'b0;
      reg_rw_q    <= 1'b0;
      reg_addr_q  <= 6'd0;
      reg_data_q  <= 8'd0;
      tx_data_q   <= 8'd0;
      start_end_q <= 1'b0;
      busy_q      <= 1'b0;
      hs_ok_q     <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
`ifdef USB_HOST_CHIRP_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      kcnt_q      <= kcnt_d;
      c_q         <= c_d;
      pairs_q     <= pairs_d;
      reg_en_q    <= reg_en_d;
      reg_rw_q    <= reg_rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_data_q  <= reg_data_d;
      tx_data_q   <= tx_data_d;
      start_end_q <= start_end_d;
      busy_q      <= busy_d;
      hs_ok_q     <= hs_ok_d;
      fs_q        <= fs_d;
      err_q       <= err_d;
`ifdef USB_HOST_CHIRP_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign bus.REG_EN                = reg_en_q;
  assign bus.REG_RW                = reg_rw_q;
  assign bus.REG_ADDR              = reg_addr_q;
  assign bus.REG_DATA_I            = reg_data_q;
  assign bus.USB_DATA_IN           = tx_data_q;
  assign bus.USB_DATA_IN_START_END = start_end_q;
  assign bus.BUSY                  = busy_q;
  assign bus.HS_OK                 = hs_ok_q;
  assign bus.FS_FALLBACK           = fs_q;
  assign bus.ERR                   = err_q;
  assign bus.STATE                 = state_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_host_chirp.sv
`default_nettype none
// ============================================================================
// Module : tb_usb_host_chirp
// Brief  : Directed/randomized bench for usb_host_chirp with an arithmetic
//          timing model of the chirp handshake.
// Rev    : 1.0  initial release
// ============================================================================
module tb_usb_host_chirp;
  localparam int K_DET   = 150;
  localparam int TMO     = 2000;
  localparam int RST_CYC = 3000;
  localparam int KJ      = 100;
  localparam int PMIN    = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  usb_host_chirp_if bus();

  usb_host_chirp #(
    .CHIRP_K_DET_CYC  (K_DET),
    .CHIRP_TIMEOUT_CYC(TMO),
    .RESET_CYC        (RST_CYC),
    .KJ_CYC           (KJ),
    .KJ_PAIRS_MIN     (PMIN)
  ) dut (
    .CLK_60M   (clk),
    .NRST_A_USB(nrst),
    .bus       (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad   = 0;
  int         pulse_q[$];
  logic [7:0] data_q[$];
  logic [7:0] reg_q[$];
  int         reg_cyc_q[$];
  int         done_q[$];
  int         reg_bad = 0;
  bit         reg_fail_mode = 1'b0;

  // TX monitor: START_END pulse cycles and the bytes between start and end.
  always @(negedge clk) begin
    if (bus.USB_DATA_IN_START_END === 1'b1) pulse_q.push_back(cyc);
    else if (pulse_q.size() % 2 == 1) data_q.push_back(bus.USB_DATA_IN);
  end

  // ULPI register responder with random latency.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (bus.REG_EN === 1'b1) begin
        reg_q.push_back(bus.REG_DATA_I);
        reg_cyc_q.push_back(cyc);
        if (bus.REG_ADDR !== 6'h04 || bus.REG_RW !== 1'b1) reg_bad++;
        lat = $urandom_range(1, 4);
        repeat (lat) @(negedge clk);
        if (reg_fail_mode) bus.REG_FAIL = 1'b1;
        else               bus.REG_DONE = 1'b1;
        done_q.push_back(cyc + 1);
        @(negedge clk);
        bus.REG_DONE = 1'b0;
        bus.REG_FAIL = 1'b0;
      end
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ls(input logic [1:0] s);
    logic [5:0] hi;
    hi = 6'($urandom);
    return {hi, s};
  endfunction

  task automatic clear_logs();
    pulse_q.delete();
    data_q.delete();
    reg_q.delete();
    reg_cyc_q.delete();
    done_q.delete();
    reg_bad = 0;
  endtask

  task automatic drive_line(input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.RXCMD = ls(s);
      @(negedge clk);
    end
  endtask

  // Issue START and wait for the chirp OpMode write to complete; e0 is the
  // edge on which REG_DONE was sampled (reset timer zeroed there).
  task automatic start_seq(input string tag, output int e0);
    int s;
    int n;
    clear_logs();
    bus.RXCMD = ls(2'b00);
    bus.READY = 1'b1;
    @(negedge clk);
    s = cyc;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    n = 0;
    while (done_q.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr1_done"}, done_q.size() > 0, 1);
    chk({tag, "_start_to_regen"}, reg_cyc_q.size() > 0 ? reg_cyc_q[0] : -1, s + 1);
    e0 = done_q.size() > 0 ? done_q[0] : cyc;
    while (cyc < e0) @(negedge clk);
  endtask

  task automatic hs_begin(input string tag, input int glitch, input int gap, input int dlen,
                          output int e0, output int s_exp);
    start_seq(tag, e0);
    if (glitch > 0) begin
      drive_line(2'b10, glitch);
      drive_line(2'b00, gap);
    end
    drive_line(2'b10, dlen);
    bus.RXCMD = ls(2'b01);
    s_exp = cyc + 1;
  endtask

  task automatic hs_finish(input string tag, input int e0, input int s_exp);
    int p;
    int n;
    int mism;
    p = PMIN;
    while (s_exp + 2 * KJ * p - e0 < RST_CYC) p++;
    n = 0;
    while ((pulse_q.size() < 2 || bus.HS_OK !== 1'b1) && n < RST_CYC + 2 * KJ * (PMIN + 2) + 2000) begin
      @(negedge clk);
      n++;
    end
    mism = 0;
    foreach (data_q[i]) begin
      if (data_q[i] !== ((((i / KJ) % 2) == 1) ? 8'hFF : 8'h00)) mism++;
    end
    chk({tag, "_pulse_cnt"}, pulse_q.size(), 2);
    chk({tag, "_tx_start_cyc"}, pulse_q.size() > 0 ? pulse_q[0] : -1, s_exp);
    chk({tag, "_tx_end_cyc"}, pulse_q.size() > 1 ? pulse_q[1] : -1, s_exp + 2 * KJ * p + 1);
    chk({tag, "_train_len"}, data_q.size(), 2 * KJ * p);
    chk({tag, "_train_pattern_errs"}, mism, 0);
    chk({tag, "_reg_cnt"}, reg_q.size(), 2);
    chk({tag, "_reg0"}, reg_q.size() > 0 ? reg_q[0] : 8'hxx, 8'h50);
    chk({tag, "_reg1"}, reg_q.size() > 1 ? reg_q[1] : 8'hxx, 8'h40);
    chk({tag, "_reg_addr_rw_errs"}, reg_bad, 0);
    chk({tag, "_hs_ok"}, bus.HS_OK, 1);
    chk({tag, "_state"}, bus.STATE, 11);
    chk({tag, "_flags"}, {bus.BUSY, bus.FS_FALLBACK, bus.ERR, bus.USB_DATA_IN_START_END}, 0);
  endtask

  initial begin
    int e0;
    int s_exp;
    int n;
    int krun;
    int fs_cyc;
    int f;
    bus.START            = 1'b0;
    bus.READY            = 1'b0;
    bus.RXCMD            = 8'h00;
    bus.REG_DONE         = 1'b0;
    bus.REG_FAIL         = 1'b0;
    bus.USB_DATA_IN_STRB = 1'b0;
    bus.USB_DATA_IN_FAIL = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_state", bus.STATE, 0);
    chk("rst_outputs", {bus.REG_EN, bus.REG_RW, bus.REG_ADDR, bus.REG_DATA_I, bus.USB_DATA_IN,
                        bus.USB_DATA_IN_START_END, bus.BUSY, bus.HS_OK, bus.FS_FALLBACK, bus.ERR}, 0);
    nrst = 1'b1;
    @(negedge clk);

    // START without READY is ignored.
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_ready_state", bus.STATE, 0);
    chk("no_ready_regs", reg_q.size(), 0);

    // Device Chirp K of 200 cycles, then J.
    hs_begin("hs_k200", 0, 0, 200, e0, s_exp);
    hs_finish("hs_k200", e0, s_exp);

    // 149-cycle K glitch must not qualify; the following 150-cycle K must.
    hs_begin("hs_glitch", 149, $urandom_range(1, 20), 150, e0, s_exp);
    hs_finish("hs_glitch", e0, s_exp);

    hs_begin("hs_rand", $urandom_range(0, 149), $urandom_range(1, 20), $urandom_range(150, 400), e0, s_exp);
    hs_finish("hs_rand", e0, s_exp);

    // No device chirp: SE0/J with short K glitches until full-speed fallback.
    start_seq("fs", e0);
    krun = 0;
    fs_cyc = -1;
    n = 0;
    while (n < TMO + 200) begin
      if (bus.FS_FALLBACK === 1'b1) begin
        fs_cyc = cyc;
        break;
      end
      if (krun > 0) begin
        bus.RXCMD = ls(2'b10);
        krun--;
      end else begin
        bus.RXCMD = ls(2'($urandom_range(0, 1)));
        if ($urandom_range(0, 29) == 0) krun = $urandom_range(1, 149);
      end
      @(negedge clk);
      n++;
    end
    chk("fs_cyc", fs_cyc, e0 + 1 + TMO);
    chk("fs_state", bus.STATE, 12);
    chk("fs_flags", {bus.FS_FALLBACK, bus.HS_OK, bus.ERR, bus.BUSY}, 4'b1000);
    chk("fs_no_tx", pulse_q.size(), 0);
    chk("fs_reg_cnt", reg_q.size(), 1);

    // First register write fails.
    clear_logs();
    reg_fail_mode = 1'b1;
    @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    n = 0;
    while (bus.ERR !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    reg_fail_mode = 1'b0;
    chk("regfail_err", bus.ERR, 1);
    chk("regfail_state", bus.STATE, 13);
    chk("regfail_busy", bus.BUSY, 0);

    // TX aborted during a J chirp.
    hs_begin("txfail", 0, 0, $urandom_range(150, 300), e0, s_exp);
    f = s_exp + KJ + $urandom_range(1, KJ - 1);
    n = 0;
    while (cyc < f && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("txfail_in_j", bus.USB_DATA_IN, 8'hFF);
    bus.USB_DATA_IN_FAIL = 1'b1;
    @(negedge clk);
    bus.USB_DATA_IN_FAIL = 1'b0;
    repeat (3) @(negedge clk);
    chk("txfail_err", bus.ERR, 1);
    chk("txfail_state", bus.STATE, 13);
    chk("txfail_data", bus.USB_DATA_IN, 0);
    chk("txfail_no_end", pulse_q.size(), 1);

    // Asynchronous reset in the middle of a K chirp.
    hs_begin("rst", 0, 0, $urandom_range(150, 300), e0, s_exp);
    f = s_exp + $urandom_range(1, KJ - 1);
    n = 0;
    while (cyc < f && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_in_txk", bus.STATE, 6);
    #2 nrst = 1'b0;
    #1;
    chk("rst_async_outs", {bus.STATE, bus.REG_EN, bus.USB_DATA_IN, bus.USB_DATA_IN_START_END,
                           bus.BUSY, bus.HS_OK, bus.FS_FALLBACK, bus.ERR}, 0);
    @(negedge clk);
    chk("rst_hold_outs", {bus.STATE, bus.USB_DATA_IN_START_END, bus.BUSY}, 0);
    chk("rst_no_end", pulse_q.size(), 1);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    hs_begin("after_rst", 0, 0, $urandom_range(150, 300), e0, s_exp);
    hs_finish("after_rst", e0, s_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
